// File: rtl/bcd_conv16_if.sv
// Handshake and result bus between the divider-side requester and bcd_conv16.
// BCD_SEG7_EN adds the five seven-segment outputs.
interface bcd_conv16_if;
   localparam int unsigned BIN_W = 16;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned SEG_W = 7;

   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   logic [DIG_W-1:0] d4, d3, d2, d1, d0;
`ifdef BCD_SEG7_EN
   logic [SEG_W-1:0] seg4, seg3, seg2, seg1, seg0;

   modport master (output start, bin,
                   input  busy, done, d4, d3, d2, d1, d0,
                          seg4, seg3, seg2, seg1, seg0);
   modport slave  (input  start, bin,
                   output busy, done, d4, d3, d2, d1, d0,
                          seg4, seg3, seg2, seg1, seg0);
`else
   modport master (output start, bin,
                   input  busy, done, d4, d3, d2, d1, d0);
   modport slave  (input  start, bin,
                   output busy, done, d4, d3, d2, d1, d0);
`endif
endinterface

// File: rtl/bcd_conv16.sv
// 16-bit binary to 5-digit BCD converter (double dabble, one shift per cycle).
// Optional active-low seven-segment outputs with leading-zero blanking under BCD_SEG7_EN.
module bcd_conv16 (
   input logic         clk,
   input logic         reset,
   bcd_conv16_if.slave bus
);
   localparam int unsigned BIN_W  = 16;
   localparam int unsigned BCD_W  = 20;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned N_DIG  = 5;
   localparam int unsigned SEG_W  = 7;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state;
   logic [BIN_W-1:0] sr;
   logic [BCD_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [BCD_W-1:0] acc_adj;
   logic [BCD_W-1:0] acc_shifted;

   // Add-3 correction on every nibble >= 5, then shift in the next binary bit
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < int'(N_DIG); i++) begin
         if (acc[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
      acc_shifted = {acc_adj[BCD_W-2:0], sr[BIN_W-1]};
   end

`ifdef BCD_SEG7_EN
   function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   logic blank4, blank3, blank2, blank1;

   // A digit blanks only when it and every more-significant digit are zero
   always_comb begin
      blank4 = (acc_shifted[19:16] == 4'd0);
      blank3 = blank4 && (acc_shifted[15:12] == 4'd0);
      blank2 = blank3 && (acc_shifted[11:8] == 4'd0);
      blank1 = blank2 && (acc_shifted[7:4] == 4'd0);
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         sr       <= '0;
         acc      <= '0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.d4   <= '0;
         bus.d3   <= '0;
         bus.d2   <= '0;
         bus.d1   <= '0;
         bus.d0   <= '0;
`ifdef BCD_SEG7_EN
         bus.seg4 <= 7'h7F;
         bus.seg3 <= 7'h7F;
         bus.seg2 <= 7'h7F;
         bus.seg1 <= 7'h7F;
         bus.seg0 <= 7'h7F;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  sr       <= bus.bin;
                  acc      <= '0;
                  cnt      <= '0;
                  state    <= S_SHIFT;
                  bus.busy <= 1'b1;
               end
            end
            S_SHIFT: begin
               acc <= acc_shifted;
               sr  <= {sr[BIN_W-2:0], 1'b0};
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_SHIFT) begin
                  state    <= S_DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.d4   <= acc_shifted[19:16];
                  bus.d3   <= acc_shifted[15:12];
                  bus.d2   <= acc_shifted[11:8];
                  bus.d1   <= acc_shifted[7:4];
                  bus.d0   <= acc_shifted[3:0];
`ifdef BCD_SEG7_EN
                  bus.seg4 <= blank4 ? 7'h7F : seg7(acc_shifted[19:16]);
                  bus.seg3 <= blank3 ? 7'h7F : seg7(acc_shifted[15:12]);
                  bus.seg2 <= blank2 ? 7'h7F : seg7(acc_shifted[11:8]);
                  bus.seg1 <= blank1 ? 7'h7F : seg7(acc_shifted[7:4]);
                  bus.seg0 <= seg7(acc_shifted[3:0]);
`endif
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_conv16.sv
// Self-checking bench for bcd_conv16: directed table, random values vs arithmetic model,
// protocol corner cases, divider-driven start and asynchronous reset abort.
module tb_bcd_conv16;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   bcd_conv16_if bif ();

   bcd_conv16 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bin;
      logic [19:0] exp_d;
      logic [34:0] exp_s;
   } vec_t;

   logic [6:0] lut [10];
   int         p10 [5];

   task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] model_bcd(input int v);
      logic [19:0] r;
      int          x;
      r = '0;
      x = v;
      for (int k = 0; k < 5; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [34:0] model_seg(input int v);
      logic [34:0] r;
      for (int k = 0; k < 5; k++) begin
         if (k > 0 && v < p10[k]) r[7*k +: 7] = 7'h7F;
         else                     r[7*k +: 7] = lut[(v / p10[k]) % 10];
      end
      return r;
   endfunction

   function automatic logic [34:0] dut_digits();
      return 35'({bif.d4, bif.d3, bif.d2, bif.d1, bif.d0});
   endfunction

   function automatic logic [34:0] dut_segs();
`ifdef BCD_SEG7_EN
      return {bif.seg4, bif.seg3, bif.seg2, bif.seg1, bif.seg0};
`else
      return '0;
`endif
   endfunction

   // Pulses start with b from an IDLE cycle; optionally injects a stray 999 request at cycle inj
   task automatic conv(input logic [15:0] b, input int inj, output int lat, output int busy_n);
      int cyc;
      cyc    = 0;
      busy_n = 0;
      bif.start = 1'b1;
      bif.bin   = b;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) bif.start = 1'b0;
         if (inj != 0 && cyc == inj)     begin bif.start = 1'b1; bif.bin = 16'd999; end
         if (inj != 0 && cyc == inj + 1) begin bif.start = 1'b0; bif.bin = b; end
         if (bif.busy) busy_n++;
      end while (!bif.done && cyc < 40);
      lat = cyc;
   endtask

   task automatic verify(input string name, input int lat, input int busy_n,
                         input logic [19:0] exp_d, input logic [34:0] exp_s);
      check({name, " latency"}, 35'(lat), 35'd17);
      check({name, " busy cycles"}, 35'(busy_n), 35'd16);
      check({name, " digits"}, dut_digits(), 35'(exp_d));
`ifdef BCD_SEG7_EN
      check({name, " segs"}, dut_segs(), exp_s);
`endif
   endtask

   initial begin
      vec_t        vecs [6];
      int          lat, busy_n, v, q, r, cyc, done_n;
      logic [15:0] rb;

      lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      p10 = '{1, 10, 100, 1000, 10000};
      vecs[0] = '{16'd0,     20'h00000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vecs[1] = '{16'd65535, 20'h65535, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
      vecs[2] = '{16'd1234,  20'h01234, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}};
      vecs[3] = '{16'd999,   20'h00999, {7'h7F, 7'h7F, 7'h10, 7'h10, 7'h10}};
      vecs[4] = '{16'd10000, 20'h10000, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}};
      vecs[5] = '{16'd9,     20'h00009, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10}};

      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b0;
      bif.start = 1'b0;
      bif.bin   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 35'(bif.busy), 35'd0);
      check("reset done", 35'(bif.done), 35'd0);
      check("reset digits", dut_digits(), 35'd0);
`ifdef BCD_SEG7_EN
      check("reset segs", dut_segs(), {5{7'h7F}});
`endif
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         conv(vecs[i].bin, 0, lat, busy_n);
         verify($sformatf("vec%0d", i), lat, busy_n, vecs[i].exp_d, vecs[i].exp_s);
         @(posedge clk); #1;
      end

      for (int i = 0; i < 30; i++) begin
         rb = 16'($urandom);
         v  = int'(rb);
         conv(rb, 0, lat, busy_n);
         verify($sformatf("rand%0d(%0d)", i, v), lat, busy_n, model_bcd(v), model_seg(v));
         @(posedge clk); #1;
      end

      // Stray request mid-conversion is dropped; request right after DONE is taken
      conv(16'd1234, 5, lat, busy_n);
      verify("ignore mid-shift", lat, busy_n, 20'h01234, model_seg(1234));
      @(posedge clk); #1;
      conv(16'd999, 0, lat, busy_n);
      verify("after done", lat, busy_n, 20'h00999, model_seg(999));
      @(posedge clk); #1;

      // Held start retriggers in the first IDLE cycle
      bif.start = 1'b1;
      bif.bin   = 16'd77;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!bif.done && cyc < 40);
      check("held latency", 35'(cyc), 35'd17);
      check("held digits", dut_digits(), 35'h00077);
      @(posedge clk); #1;
      check("held idle busy", 35'(bif.busy), 35'd0);
      @(posedge clk); #1;
      check("held retrigger busy", 35'(bif.busy), 35'd1);
      bif.start = 1'b0;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!bif.done && cyc < 40);
      check("retrigger remaining", 35'(cyc), 35'd16);
      @(posedge clk); #1;

      // Repeated-subtraction divider 1000/7 with its result pulse driving start
      q = 0;
      r = 1000;
      while (r >= 7) begin
         r = r - 7;
         q++;
         @(posedge clk); #1;
      end
      conv(16'(q), 0, lat, busy_n);
      verify("divider 1000/7", lat, busy_n, 20'h00142, model_seg(142));
      @(posedge clk); #1;

      // Asynchronous reset mid-conversion
      bif.start = 1'b1;
      bif.bin   = 16'd4321;
      @(posedge clk); #1;
      bif.start = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      check("mid busy", 35'(bif.busy), 35'd1);
      check("mid digits held", dut_digits(), 35'h00142);
      reset = 1'b0;
      #1;
      check("abort busy", 35'(bif.busy), 35'd0);
      check("abort done", 35'(bif.done), 35'd0);
      check("abort digits", dut_digits(), 35'd0);
`ifdef BCD_SEG7_EN
      check("abort segs", dut_segs(), {5{7'h7F}});
`endif
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      done_n = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bif.done || bif.busy) done_n++;
      end
      check("no done after abort", 35'(done_n), 35'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
